// File: rtl/shift_pkg.sv
// ----------------------------------------------------------------------------
// shift_pkg
// Definitions shared by the shift sequencer and the 8-bit mode-controlled
// shift register it drives.
//   - MODE_*  : {s1,s0} encodings understood by the shift register.
//   - ST_*    : sequencer FSM state encoding.
// ----------------------------------------------------------------------------
package shift_pkg;

   // Shift register mode select {s1,s0}
   localparam logic [1:0] MODE_LOAD = 2'b00;
   localparam logic [1:0] MODE_SHR  = 2'b01;
   localparam logic [1:0] MODE_SHL  = 2'b10;
   localparam logic [1:0] MODE_HOLD = 2'b11;

   // Sequencer FSM states
   localparam logic [1:0] ST_IDLE  = 2'b00;
   localparam logic [1:0] ST_LOAD  = 2'b01;
   localparam logic [1:0] ST_SHIFT = 2'b10;
   localparam logic [1:0] ST_DONE  = 2'b11;

endpackage : shift_pkg

// File: rtl/shift_sequencer.sv
// ----------------------------------------------------------------------------
// shift_sequencer
// Command stage for the 8-bit mode-controlled shift register. One command
// (data, direction, count, fill) is accepted over valid/ready; the sequencer
// then drives one load cycle, count shift cycles and a one-cycle done pulse.
// A shadow copy of the register tracks what the register must hold, so the
// expected final word is reported without reading the register back.
//
// Ports:
//   clock, reset            : clock, asynchronous active-high reset
//   cmd_valid / cmd_ready   : command handshake (ready only in IDLE)
//   cmd_data, cmd_dir,
//   cmd_count, cmd_fill     : command payload (dir 0 = right, 1 = left)
//   sr_in                   : parallel load data to the shift register
//   sr_s1, sr_s0            : shift register mode select
//   sr_enable               : shift register enable
//   sr_left_shift,
//   sr_right_shift          : serial-in lines for left / right shifts
//   busy                    : high in LOAD, SHIFT and DONE
//   done                    : one-cycle pulse in DONE
//   exp_out                 : shadow register value (expected register word)
// ----------------------------------------------------------------------------
module shift_sequencer
   import shift_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 4
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [WIDTH-1:0] cmd_data,
   input  logic             cmd_dir,
   input  logic [CNT_W-1:0] cmd_count,
   input  logic             cmd_fill,
   output logic [WIDTH-1:0] sr_in,
   output logic             sr_s1,
   output logic             sr_s0,
   output logic             sr_enable,
   output logic             sr_left_shift,
   output logic             sr_right_shift,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] exp_out
);

   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [WIDTH-1:0] WORD_ZERO = {WIDTH{1'b0}};

   // One shift step of the register: right inserts fill at the MSB,
   // left inserts fill at the LSB.
   function automatic logic [WIDTH-1:0] shift_word(
      input logic [WIDTH-1:0] word,
      input logic             dir,
      input logic             fill
   );
      logic [WIDTH-1:0] result;
      if (dir) begin
         result = {word[WIDTH-2:0], fill};
      end else begin
         result = {fill, word[WIDTH-1:1]};
      end
      return result;
   endfunction

   // FSM and command latches
   logic [1:0]       state_r;
   logic [1:0]       state_next_s;
   logic             accept_s;
   logic [WIDTH-1:0] data_r;
   logic             dir_r;
   logic             fill_r;
   logic [CNT_W-1:0] cnt_r;
   logic [WIDTH-1:0] shadow_r;

   // Registered outputs and their next values
   logic [WIDTH-1:0] sr_in_r;
   logic [1:0]       mode_r;
   logic             enable_r;
   logic             left_r;
   logic             right_r;
   logic             busy_r;
   logic             done_r;
   logic [1:0]       mode_next_s;
   logic             enable_next_s;
   logic             left_next_s;
   logic             right_next_s;
   logic             busy_next_s;
   logic             done_next_s;

   assign cmd_ready = (state_r == ST_IDLE) && !reset;
   assign accept_s  = cmd_valid && cmd_ready;

   // Next-state logic. The down-counter holds the number of shifts still to
   // perform, so SHIFT ends on the cycle where it reads one.
   always_comb begin
      state_next_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (accept_s) begin
               state_next_s = ST_LOAD;
            end else begin
               state_next_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            if (cnt_r != CNT_ZERO) begin
               state_next_s = ST_SHIFT;
            end else begin
               state_next_s = ST_DONE;
            end
         end
         ST_SHIFT: begin
            if (cnt_r == CNT_ONE) begin
               state_next_s = ST_DONE;
            end else begin
               state_next_s = ST_SHIFT;
            end
         end
         ST_DONE: begin
            state_next_s = ST_IDLE;
         end
         default: begin
            state_next_s = ST_IDLE;
         end
      endcase
   end

   // Output decode from the next state, so the registered outputs line up
   // with the state the FSM is in during the same cycle.
   always_comb begin
      mode_next_s   = MODE_HOLD;
      enable_next_s = 1'b0;
      left_next_s   = 1'b0;
      right_next_s  = 1'b0;
      done_next_s   = 1'b0;
      busy_next_s   = (state_next_s != ST_IDLE);
      case (state_next_s)
         ST_IDLE: begin
            mode_next_s   = MODE_HOLD;
            enable_next_s = 1'b0;
         end
         ST_LOAD: begin
            mode_next_s   = MODE_LOAD;
            enable_next_s = 1'b1;
         end
         ST_SHIFT: begin
            // dir_r/fill_r are already latched: SHIFT is only entered from
            // LOAD or SHIFT, never straight from IDLE.
            enable_next_s = 1'b1;
            if (dir_r) begin
               mode_next_s = MODE_SHL;
               left_next_s = fill_r;
            end else begin
               mode_next_s  = MODE_SHR;
               right_next_s = fill_r;
            end
         end
         ST_DONE: begin
            mode_next_s = MODE_HOLD;
            done_next_s = 1'b1;
         end
         default: begin
            mode_next_s   = MODE_HOLD;
            enable_next_s = 1'b0;
         end
      endcase
   end

   // State register, command latches and down-counter
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_r <= ST_IDLE;
         data_r  <= WORD_ZERO;
         dir_r   <= 1'b0;
         fill_r  <= 1'b0;
         cnt_r   <= CNT_ZERO;
      end else begin
         state_r <= state_next_s;
         case (state_r)
            ST_IDLE: begin
               if (accept_s) begin
                  data_r <= cmd_data;
                  dir_r  <= cmd_dir;
                  fill_r <= cmd_fill;
                  cnt_r  <= cmd_count;
               end
            end
            ST_SHIFT: begin
               cnt_r <= cnt_r - CNT_ONE;
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

   // Shadow register: mirrors what the shift register holds after each edge
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         shadow_r <= WORD_ZERO;
      end else begin
         case (state_r)
            ST_LOAD:  shadow_r <= data_r;
            ST_SHIFT: shadow_r <= shift_word(shadow_r, dir_r, fill_r);
            default:  shadow_r <= shadow_r;
         endcase
      end
   end

   // Registered shift register controls, status and parallel data
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sr_in_r  <= WORD_ZERO;
         mode_r   <= MODE_HOLD;
         enable_r <= 1'b0;
         left_r   <= 1'b0;
         right_r  <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
      end else begin
         // sr_in keeps the last loaded word until the next accepted command
         if (accept_s) begin
            sr_in_r <= cmd_data;
         end
         mode_r   <= mode_next_s;
         enable_r <= enable_next_s;
         left_r   <= left_next_s;
         right_r  <= right_next_s;
         busy_r   <= busy_next_s;
         done_r   <= done_next_s;
      end
   end

   assign sr_in          = sr_in_r;
   assign sr_s1          = mode_r[1];
   assign sr_s0          = mode_r[0];
   assign sr_enable      = enable_r;
   assign sr_left_shift  = left_r;
   assign sr_right_shift = right_r;
   assign busy           = busy_r;
   assign done           = done_r;
   assign exp_out        = shadow_r;

endmodule : shift_sequencer

// File: tb/tb_shift_sequencer.sv
// ----------------------------------------------------------------------------
// tb_shift_sequencer
// Self-checking bench for shift_sequencer. A behavioural 8-bit shift register
// is attached to the sr_* outputs; expected words are queued when commands
// are driven and popped when done pulses.
// ----------------------------------------------------------------------------
module tb_shift_sequencer;

   localparam int WIDTH = 8;
   localparam int CNT_W = 4;

   logic             clock = 1'b0;
   logic             reset;
   logic             cmd_valid;
   logic             cmd_ready;
   logic [WIDTH-1:0] cmd_data;
   logic             cmd_dir;
   logic [CNT_W-1:0] cmd_count;
   logic             cmd_fill;
   logic [WIDTH-1:0] sr_in;
   logic             sr_s1;
   logic             sr_s0;
   logic             sr_enable;
   logic             sr_left_shift;
   logic             sr_right_shift;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] exp_out;

   int vectors     = 0;
   int miscompares = 0;

   logic [7:0] exp_q[$];
   logic [7:0] sr_model;

   shift_sequencer #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clock          (clock),
      .reset          (reset),
      .cmd_valid      (cmd_valid),
      .cmd_ready      (cmd_ready),
      .cmd_data       (cmd_data),
      .cmd_dir        (cmd_dir),
      .cmd_count      (cmd_count),
      .cmd_fill       (cmd_fill),
      .sr_in          (sr_in),
      .sr_s1          (sr_s1),
      .sr_s0          (sr_s0),
      .sr_enable      (sr_enable),
      .sr_left_shift  (sr_left_shift),
      .sr_right_shift (sr_right_shift),
      .busy           (busy),
      .done           (done),
      .exp_out        (exp_out)
   );

   always #5 clock = ~clock;

   // Behavioural shift register driven by the sequencer
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sr_model <= 8'h00;
      end else if (sr_enable) begin
         case ({sr_s1, sr_s0})
            2'b00:   sr_model <= sr_in;
            2'b01:   sr_model <= {sr_right_shift, sr_model[7:1]};
            2'b10:   sr_model <= {sr_model[6:0], sr_left_shift};
            default: sr_model <= sr_model;
         endcase
      end
   end

   // Reference result of a command
   function automatic logic [7:0] model_result(input logic [7:0] d, input logic dir,
                                               input int cnt, input logic fill);
      logic [7:0] w;
      w = d;
      for (int i = 0; i < cnt; i++) begin
         w = dir ? {w[6:0], fill} : {fill, w[7:1]};
      end
      return w;
   endfunction

   // Drive one command for a single accepting edge and queue its expected word
   task automatic send_cmd(input logic [7:0] d, input logic dir, input int cnt, input logic fill);
      @(negedge clock);
      cmd_data  = d;
      cmd_dir   = dir;
      cmd_count = cnt[CNT_W-1:0];
      cmd_fill  = fill;
      cmd_valid = 1'b1;
      exp_q.push_back(model_result(d, dir, cnt, fill));
      @(posedge clock);
      #1 cmd_valid = 1'b0;
   endtask

   // Observe cycles 1..budget after acceptance, stopping at the done cycle
   task automatic collect(input int budget, input logic fill,
                          output int done_cycle, output int n_load, output int n_shr,
                          output int n_shl, output int n_bad_serial, output int n_ready_busy,
                          output logic [7:0] load_data, output logic [7:0] exp_val,
                          output logic [7:0] reg_val);
      done_cycle = 0; n_load = 0; n_shr = 0; n_shl = 0; n_bad_serial = 0; n_ready_busy = 0;
      load_data = 8'h00; exp_val = 8'h00; reg_val = 8'h00;
      for (int c = 1; c <= budget; c++) begin
         @(negedge clock);
         if (sr_enable && {sr_s1, sr_s0} == 2'b00) begin
            n_load++;
            load_data = sr_in;
         end
         if (sr_enable && {sr_s1, sr_s0} == 2'b01) begin
            n_shr++;
            if (sr_right_shift !== fill || sr_left_shift !== 1'b0) n_bad_serial++;
         end
         if (sr_enable && {sr_s1, sr_s0} == 2'b10) begin
            n_shl++;
            if (sr_left_shift !== fill || sr_right_shift !== 1'b0) n_bad_serial++;
         end
         if (busy && cmd_ready) n_ready_busy++;
         if (done) begin
            done_cycle = c;
            exp_val    = exp_out;
            reg_val    = sr_model;
            break;
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge clock);
      vectors++;
      if ({sr_s1, sr_s0, sr_enable, sr_left_shift, sr_right_shift, busy, done, cmd_ready} !== 8'b1100_0000) begin
         miscompares++;
         $display("FAIL reset_ctrl: got %b expected 11000000",
                  {sr_s1, sr_s0, sr_enable, sr_left_shift, sr_right_shift, busy, done, cmd_ready});
      end
      vectors++;
      if (exp_out !== 8'h00 || sr_in !== 8'h00) begin
         miscompares++;
         $display("FAIL reset_data: exp_out=%h sr_in=%h expected 00/00", exp_out, sr_in);
      end
      reset = 1'b0;
      @(negedge clock);
      vectors++;
      if (cmd_ready !== 1'b1) begin
         miscompares++;
         $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
      end
   endtask

   task automatic test_shift_right();
      int dc, nl, nr, nlft, nbad, nrb;
      logic [7:0] ld, ev, rv, e;
      send_cmd(8'h5B, 1'b0, 1, 1'b1);
      collect(20, 1'b1, dc, nl, nr, nlft, nbad, nrb, ld, ev, rv);
      vectors++;
      if (dc != 3) begin miscompares++; $display("FAIL shr_done_cycle: got %0d expected 3", dc); end
      vectors++;
      if (nl != 1 || ld !== 8'h5B) begin
         miscompares++; $display("FAIL shr_load: loads=%0d data=%h expected 1/5b", nl, ld);
      end
      vectors++;
      if (nr != 1 || nlft != 0 || nbad != 0) begin
         miscompares++; $display("FAIL shr_modes: shr=%0d shl=%0d bad_serial=%0d expected 1/0/0", nr, nlft, nbad);
      end
      if (exp_q.size() == 0) begin
         vectors++; miscompares++; $display("FAIL shr_scoreboard: queue empty expected 1 entry");
      end else begin
         e = exp_q.pop_front();
         vectors++;
         if (ev !== e) begin miscompares++; $display("FAIL shr_exp_out: got %h expected %h", ev, e); end
      end
      vectors++;
      if (rv !== 8'hAD) begin miscompares++; $display("FAIL shr_register: got %h expected ad", rv); end
      vectors++;
      if (nrb != 0) begin miscompares++; $display("FAIL shr_ready_busy: got %0d cycles expected 0", nrb); end
      @(negedge clock);
      vectors++;
      if (done !== 1'b0 || busy !== 1'b0 || cmd_ready !== 1'b1 || exp_out !== 8'hAD) begin
         miscompares++;
         $display("FAIL shr_after_done: done=%b busy=%b ready=%b exp_out=%h expected 0/0/1/ad",
                  done, busy, cmd_ready, exp_out);
      end
   endtask

   task automatic test_shift_left();
      int dc, nl, nr, nlft, nbad, nrb;
      logic [7:0] ld, ev, rv, e;
      send_cmd(8'h5B, 1'b1, 2, 1'b0);
      collect(20, 1'b0, dc, nl, nr, nlft, nbad, nrb, ld, ev, rv);
      vectors++;
      if (dc != 4) begin miscompares++; $display("FAIL shl_done_cycle: got %0d expected 4", dc); end
      vectors++;
      if (nlft != 2 || nr != 0 || nbad != 0) begin
         miscompares++; $display("FAIL shl_modes: shl=%0d shr=%0d bad_serial=%0d expected 2/0/0", nlft, nr, nbad);
      end
      if (exp_q.size() == 0) begin
         vectors++; miscompares++; $display("FAIL shl_scoreboard: queue empty expected 1 entry");
      end else begin
         e = exp_q.pop_front();
         vectors++;
         if (ev !== e) begin miscompares++; $display("FAIL shl_exp_out: got %h expected %h", ev, e); end
      end
      vectors++;
      if (rv !== 8'h6C) begin miscompares++; $display("FAIL shl_register: got %h expected 6c", rv); end
   endtask

   task automatic test_count_zero();
      int dc, nl, nr, nlft, nbad, nrb;
      logic [7:0] ld, ev, rv, e;
      send_cmd(8'h5B, 1'b0, 0, 1'b1);
      collect(20, 1'b1, dc, nl, nr, nlft, nbad, nrb, ld, ev, rv);
      vectors++;
      if (dc != 2) begin miscompares++; $display("FAIL cnt0_done_cycle: got %0d expected 2", dc); end
      vectors++;
      if (nl != 1 || nr != 0 || nlft != 0) begin
         miscompares++; $display("FAIL cnt0_modes: load=%0d shr=%0d shl=%0d expected 1/0/0", nl, nr, nlft);
      end
      if (exp_q.size() == 0) begin
         vectors++; miscompares++; $display("FAIL cnt0_scoreboard: queue empty expected 1 entry");
      end else begin
         e = exp_q.pop_front();
         vectors++;
         if (ev !== e || rv !== e) begin
            miscompares++; $display("FAIL cnt0_result: exp_out=%h register=%h expected %h", ev, rv, e);
         end
      end
   endtask

   task automatic test_long_count();
      int dc, nl, nr, nlft, nbad, nrb;
      logic [7:0] ld, ev, rv, e;
      send_cmd(8'hFF, 1'b0, 9, 1'b0);
      collect(30, 1'b0, dc, nl, nr, nlft, nbad, nrb, ld, ev, rv);
      vectors++;
      if (dc != 11) begin miscompares++; $display("FAIL long_done_cycle: got %0d expected 11", dc); end
      vectors++;
      if (nr != 9 || nbad != 0) begin
         miscompares++; $display("FAIL long_shifts: shr=%0d bad_serial=%0d expected 9/0", nr, nbad);
      end
      if (exp_q.size() == 0) begin
         vectors++; miscompares++; $display("FAIL long_scoreboard: queue empty expected 1 entry");
      end else begin
         e = exp_q.pop_front();
         vectors++;
         if (ev !== e || rv !== 8'h00) begin
            miscompares++; $display("FAIL long_result: exp_out=%h register=%h expected %h/00", ev, rv, e);
         end
      end
   endtask

   task automatic test_back_to_back();
      int accept_cycle = 0;
      int ready_bad    = 0;
      int n_done       = 0;
      logic drop_valid = 1'b0;
      logic [7:0] e;
      @(negedge clock);
      cmd_data = 8'hC3; cmd_dir = 1'b0; cmd_count = 4'd1; cmd_fill = 1'b0;
      cmd_valid = 1'b1;
      vectors++;
      if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_idle: got %b expected 1", cmd_ready); end
      exp_q.push_back(model_result(8'hC3, 1'b0, 1, 1'b0));
      @(posedge clock);
      for (int c = 1; c <= 12; c++) begin
         @(negedge clock);
         if (drop_valid) begin
            cmd_valid  = 1'b0;
            drop_valid = 1'b0;
         end
         if (c <= 3 && cmd_ready) ready_bad++;
         if (done) begin
            n_done++;
            if (exp_q.size() == 0) begin
               vectors++; miscompares++; $display("FAIL b2b_scoreboard: done with empty queue at cycle %0d", c);
            end else begin
               e = exp_q.pop_front();
               vectors++;
               if (exp_out !== e || sr_model !== e) begin
                  miscompares++;
                  $display("FAIL b2b_result: exp_out=%h register=%h expected %h", exp_out, sr_model, e);
               end
            end
         end
         if (c == 1) begin
            cmd_data = 8'h3C; cmd_dir = 1'b1; cmd_count = 4'd1; cmd_fill = 1'b1;
         end
         if (cmd_valid && cmd_ready && accept_cycle == 0) begin
            accept_cycle = c;
            exp_q.push_back(model_result(8'h3C, 1'b1, 1, 1'b1));
            drop_valid = 1'b1;
         end
      end
      cmd_valid = 1'b0;
      vectors++;
      if (accept_cycle != 4) begin miscompares++; $display("FAIL b2b_accept: got cycle %0d expected 4", accept_cycle); end
      vectors++;
      if (ready_bad != 0) begin miscompares++; $display("FAIL b2b_ready_busy: got %0d cycles expected 0", ready_bad); end
      vectors++;
      if (n_done != 2) begin miscompares++; $display("FAIL b2b_done_count: got %0d expected 2", n_done); end
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++; $display("FAIL b2b_leftover: got %0d queued expected 0", exp_q.size());
         exp_q.delete();
      end
   endtask

   task automatic test_reset_mid();
      int n_done = 0;
      int dc, nl, nr, nlft, nbad, nrb;
      logic [7:0] ld, ev, rv, e;
      send_cmd(8'hA5, 1'b1, 5, 1'b1);
      repeat (3) @(negedge clock);
      vectors++;
      if ({sr_s1, sr_s0} !== 2'b10 || busy !== 1'b1) begin
         miscompares++; $display("FAIL rst_mid_pre: mode=%b busy=%b expected 10/1", {sr_s1, sr_s0}, busy);
      end
      reset = 1'b1;
      #1;
      vectors++;
      if ({sr_s1, sr_s0, sr_enable, sr_left_shift, sr_right_shift, busy, done, cmd_ready} !== 8'b1100_0000) begin
         miscompares++;
         $display("FAIL rst_mid_ctrl: got %b expected 11000000",
                  {sr_s1, sr_s0, sr_enable, sr_left_shift, sr_right_shift, busy, done, cmd_ready});
      end
      vectors++;
      if (exp_out !== 8'h00 || sr_in !== 8'h00) begin
         miscompares++; $display("FAIL rst_mid_data: exp_out=%h sr_in=%h expected 00/00", exp_out, sr_in);
      end
      exp_q.delete();
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      @(negedge clock);
      vectors++;
      if (cmd_ready !== 1'b1) begin miscompares++; $display("FAIL rst_mid_ready: got %b expected 1", cmd_ready); end
      for (int c = 0; c < 8; c++) begin
         @(negedge clock);
         if (done) n_done++;
      end
      vectors++;
      if (n_done != 0) begin miscompares++; $display("FAIL rst_mid_no_done: got %0d pulses expected 0", n_done); end
      send_cmd(8'h81, 1'b0, 3, 1'b1);
      collect(20, 1'b1, dc, nl, nr, nlft, nbad, nrb, ld, ev, rv);
      vectors++;
      if (dc != 5 || nr != 3 || nbad != 0) begin
         miscompares++; $display("FAIL rst_mid_next: done_cycle=%0d shr=%0d bad=%0d expected 5/3/0", dc, nr, nbad);
      end
      if (exp_q.size() == 0) begin
         vectors++; miscompares++; $display("FAIL rst_mid_scoreboard: queue empty expected 1 entry");
      end else begin
         e = exp_q.pop_front();
         vectors++;
         if (ev !== e || rv !== 8'hF0) begin
            miscompares++; $display("FAIL rst_mid_result: exp_out=%h register=%h expected %h/f0", ev, rv, e);
         end
      end
   endtask

   initial begin
      reset     = 1'b1;
      cmd_valid = 1'b0;
      cmd_data  = 8'h00;
      cmd_dir   = 1'b0;
      cmd_count = 4'd0;
      cmd_fill  = 1'b0;
      test_reset();
      test_shift_right();
      test_shift_left();
      test_count_zero();
      test_long_count();
      test_back_to_back();
      test_reset_mid();
      repeat (2) @(negedge clock);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_shift_sequencer
